io_input_conditioner: RTL



---
 rtl/io_input_conditioner.sv | 94 +++++++++
 1 files changed

// File: rtl/io_input_conditioner.sv
// Board input conditioner for the RV32I core: two-flop synchronizers, per-bit debounce,
// zero-extended io buses, press/change event pulses and the core's active-low run switch.
module io_input_conditioner #(
    parameter int unsigned SW_WIDTH        = 18,
    parameter int unsigned PUSH_WIDTH      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [SW_WIDTH-1:0]   sw_raw_i,
    input  logic [PUSH_WIDTH-1:0] key_raw_i,
    output logic [31:0]           io_sw_o,
    output logic [31:0]           io_push_o,
    output logic [PUSH_WIDTH-1:0] push_press_o,
    output logic                  sw_change_o,
    output logic                  cpu_rst_no
);

    localparam int unsigned N  = SW_WIDTH + PUSH_WIDTH;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    // Idle raw levels: switches low, keys high (released).
    localparam logic [N-1:0] IDLE = {{PUSH_WIDTH{1'b1}}, {SW_WIDTH{1'b0}}};

    logic [N-1:0]          raw;
    logic [N-1:0]          sync1;
    logic [N-1:0]          sync2;
    logic [N-1:0]          stable;
    logic [CW-1:0]         cnt [N];
    logic [SW_WIDTH-1:0]   sw_stable;
    logic [SW_WIDTH-1:0]   sw_prev;
    logic [PUSH_WIDTH-1:0] pushed;
    logic [PUSH_WIDTH-1:0] pushed_prev;

    assign raw = {key_raw_i, sw_raw_i};

    // Two-flop synchronizer, one pair per bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: any return to the stable level restarts the full count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stable <= IDLE;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign sw_stable = stable[SW_WIDTH-1:0];
    assign pushed    = ~stable[N-1:SW_WIDTH];

    // Registered edge detects on the debounced levels.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sw_prev      <= '0;
            pushed_prev  <= '0;
            push_press_o <= '0;
            sw_change_o  <= 1'b0;
        end else begin
            sw_prev      <= sw_stable;
            pushed_prev  <= pushed;
            push_press_o <= pushed & ~pushed_prev;
            sw_change_o  <= |(sw_stable ^ sw_prev);
        end
    end

    always_comb begin
        io_sw_o                    = '0;
        io_push_o                  = '0;
        io_sw_o[SW_WIDTH-1:0]      = sw_stable;
        io_push_o[PUSH_WIDTH-1:0]  = pushed;
    end

    assign cpu_rst_no = stable[SW_WIDTH-1];

endmodule
